if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, meaning the clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-004 SHALL have port stall, input, 6, meaning the pipeline stall vector; bit0 = PC/IF stop, 1 = Stop.
REQ-005 SHALL have port branch_flag_i, input, 1, meaning a taken branch in decode.
REQ-006 SHALL have port branch_target_i, input, 32, meaning the branch target address.
REQ-007 SHALL have port flush_i, input, 1, meaning an exception/flush redirect.
REQ-008 SHALL have port new_pc_i, input, 32, meaning the flush target address.
REQ-009 SHALL have port inst_req_o, output, 1, meaning an instruction memory request.
REQ-010 SHALL have port inst_addr_o, output, 32, meaning the request address.
REQ-011 SHALL have port inst_ack_i, input, 1, meaning that memory data is valid this cycle.
REQ-012 SHALL have port inst_rdata_i, input, 32, meaning the memory read data.
REQ-013 SHALL have port if_pc, output, 32, meaning the fetched instruction address to IF/ID.
REQ-014 SHALL have port if_inst, output, 32, meaning the fetched instruction to IF/ID.
REQ-015 SHALL have port stallreq_o, output, 1, meaning the fetch-not-ready stall request to ctrl.

Function
REQ-016 SHALL implement a state machine with states IDLE, FETCH and READY.
REQ-017 SHALL hold a registered pc, plus redir_valid/redir_target and a discard flag.
REQ-018 SHALL drive inst_req_o = (state==FETCH), inst_addr_o = pc, and stallreq_o = (state!=READY), all combinationally.
REQ-019 In IDLE, SHALL move to FETCH next cycle.
REQ-020 In FETCH with inst_ack_i=0, SHALL stay in FETCH and hold inst_addr_o stable.
REQ-021 In FETCH with inst_ack_i=1 and discard=0, SHALL register if_pc<=pc and if_inst<=inst_rdata_i, then move to READY, so fetch latency is at least 2 cycles from IDLE.
REQ-022 In FETCH with inst_ack_i=1 and discard=1, SHALL drop the data, clear discard, and move to IDLE.
REQ-023 In READY with stall[0]=1, SHALL hold pc, if_pc, if_inst and state.
REQ-024 In READY with stall[0]=0 (advance), SHALL set pc <= redir_valid ? redir_target : branch_flag_i ? branch_target_i : pc+4.
REQ-025 On advance, SHALL clear redir_valid and move to FETCH; IF/ID captures if_pc/if_inst on this same edge.
REQ-026 When branch_flag_i=1 on a cycle without an advance, SHALL set redir_valid=1 and redir_target=branch_target_i; a later branch overwrites it.
REQ-027 SHALL compute pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000) and SHALL NOT check alignment.
REQ-028 flush_i=1 SHALL take priority over all other events and set pc<=new_pc_i, redir_valid<=0, if_pc<=0, if_inst<=0.
REQ-029 On flush in FETCH without ack, SHALL set discard=1 and stay in FETCH with the request address unchanged.
REQ-030 On flush in FETCH with ack, or in IDLE or READY, SHALL move to IDLE.
REQ-031 On flush in FETCH without ack, inst_addr_o SHALL keep showing the old address until ack, then switch to new_pc_i on the refetch.

Reset
REQ-032 While rst=1 at a clock edge, SHALL set state=IDLE, pc=RESET_PC, if_pc=0, if_inst=0, redir_valid=0 and discard=0.
REQ-033 Reset SHALL override every other input, including mid-FETCH; an outstanding ack after reset SHALL be ignored because state is IDLE.
REQ-034 Immediately after reset, SHALL drive inst_req_o=0 and stallreq_o=1.

Verification
REQ-035 Release rst, ack on the first FETCH cycle, data 0x3401_0001 -> if_pc=0x0, if_inst=0x3401_0001 in READY; stallreq_o falls; next request address 0x4.
REQ-036 Ack delayed 3 cycles -> inst_req_o and inst_addr_o stable for 4 cycles, stallreq_o=1 throughout, then READY.
REQ-037 READY at pc=0x8, stall[0]=1 for 2 cycles with branch_flag_i=1 and target 0x100 on the first -> outputs held; on release the next address is 0x100.
REQ-038 flush_i=1, new_pc_i=0x20 during an outstanding FETCH of 0x10, ack 2 cycles later -> data dropped, IDLE, then FETCH at 0x20; if_inst=0 meanwhile.
REQ-039 pc=0xFFFF_FFFC advances with no branch -> next request address 0x0000_0000.
REQ-040 rst asserted mid-FETCH with ack on the same edge -> all outputs at reset values and the ack data discarded.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: a single-outstanding request FSM that holds the PC, a pending redirect,
// and a discard flag for responses made stale by a flush.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StReady} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_target_q, redir_target_d;
  logic        discard_q, discard_d;
  // Flush target parked while the stale request is still outstanding.
  logic [31:0] flush_pc_q, flush_pc_d;
  logic        advance;

  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pc_q           <= RESET_PC;
      if_pc_q        <= 32'h0;
      if_inst_q      <= 32'h0;
      redir_valid_q  <= 1'b0;
      redir_target_q <= 32'h0;
      discard_q      <= 1'b0;
      flush_pc_q     <= RESET_PC;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_pc_q        <= if_pc_d;
      if_inst_q      <= if_inst_d;
      redir_valid_q  <= redir_valid_d;
      redir_target_q <= redir_target_d;
      discard_q      <= discard_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_pc_d        = if_pc_q;
    if_inst_d      = if_inst_q;
    redir_valid_d  = redir_valid_q;
    redir_target_d = redir_target_q;
    discard_d      = discard_q;
    flush_pc_d     = flush_pc_q;
    advance        = 1'b0;

    if (flush_i) begin
      redir_valid_d = 1'b0;
      if_pc_d       = 32'h0;
      if_inst_d     = 32'h0;
      if (state_q == StFetch && !inst_ack_i) begin
        // Keep the bus address stable until the in-flight response returns.
        discard_d  = 1'b1;
        flush_pc_d = new_pc_i;
      end else begin
        pc_d      = new_pc_i;
        discard_d = 1'b0;
        state_d   = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StFetch;
        StFetch: begin
          if (inst_ack_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              pc_d      = flush_pc_q;
              state_d   = StIdle;
            end else begin
              if_pc_d   = pc_q;
              if_inst_d = inst_rdata_i;
              state_d   = StReady;
            end
          end
        end
        StReady: advance = !stall[0];
        default: state_d = StIdle;
      endcase

      if (advance) begin
        if (redir_valid_q) begin
          pc_d = redir_target_q;
        end else if (branch_flag_i) begin
          pc_d = branch_target_i;
        end else begin
          pc_d = pc_q + 32'd4;
        end
        redir_valid_d = 1'b0;
        state_d       = StFetch;
      end else if (branch_flag_i) begin
        redir_valid_d  = 1'b1;
        redir_target_d = branch_target_i;
      end
    end
  end

  assign inst_req_o  = (state_q == StFetch);
  assign inst_addr_o = pc_q;
  assign stallreq_o  = (state_q != StReady);
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;

endmodule
